fifo_rd_side_ctrl: RTL

- Second-generation read-domain controller for the dual-clock FIFO. It replaces the fixed read module and its external two-register synchroniser pair.
- Synchronises the Gray write pointer internally over a parametrised number of stages. Drives the RAM read port and a registered output stage.
- Supports standard and first-word-fall-through (FWFT) modes, and reports fill level, almost-empty and sticky underflow.
- Sits between the dual-clock RAM read port and the read-side consumer.

---
 rtl/fifo_rd_side_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_rd_side_ctrl.sv
// fifo_rd_side_ctrl: read-domain controller of a dual-clock FIFO with internal wptr sync, standard/FWFT output and level flags
module fifo_rd_side_ctrl #(
  parameter int W_DATA      = 8,
  parameter int W_ADDR      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2,
  parameter int FWFT        = 0
) (
  input  logic              rd_clk,
  input  logic              reset,
  input  logic              pop,
  input  logic [W_ADDR:0]   wptr_gray,
  output logic [W_ADDR:0]   rptr_gray,
  output logic              ram_rd_en,
  output logic [W_ADDR-1:0] ram_rd_addr,
  input  logic [W_DATA-1:0] ram_rd_data,
  output logic [W_DATA-1:0] data_out,
  output logic              data_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [W_ADDR:0]   rd_level,
  output logic              underflow
);
  localparam int W1 = W_ADDR + 1;
  localparam logic [W_ADDR:0] AE = W1'(AE_THRESH);
  logic [W_ADDR:0] sync_q [SYNC_STAGES];
  logic [W_ADDR:0] wbin_s, rbin, rbin_next, ram_avail, avail_next, level_n;
  logic [W_DATA-1:0] skid0, skid1, s0_n, s1_n;
  logic [1:0] cnt, cnt_p, cnt_n;
  logic [2:0] occ;
  logic pend, empty_q, pop_ok, shift;
  // Write-pointer synchroniser chain; only the last stage is ever decoded
  always_ff @(posedge rd_clk or negedge reset)
    if (!reset)
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else begin
      sync_q[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  // Gray-to-binary of the synchronised write pointer
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < W1; i++) wbin_s[i] = ^(sync_q[SYNC_STAGES-1] >> i);
  end
  assign ram_avail   = wbin_s - rbin;
  assign pop_ok      = pop && !empty;
  assign occ         = {1'b0, cnt} + {2'b0, pend};
  assign ram_rd_en   = (FWFT != 0) ? (ram_avail != '0) && (occ < (pop_ok ? 3'd3 : 3'd2)) : pop_ok;
  assign rbin_next   = rbin + W1'(ram_rd_en);
  assign avail_next  = wbin_s - rbin_next;
  assign ram_rd_addr = rbin[W_ADDR-1:0];
  assign data_out    = skid0;
  assign data_valid  = cnt != 2'd0;
  assign empty       = (FWFT != 0) ? (cnt == 2'd0) : empty_q;
  // Output stage: a plain capture register in standard mode, a 2-entry skid buffer in FWFT mode
  always_comb begin
    shift   = (FWFT != 0) && pop_ok;
    cnt_p   = cnt - {1'b0, shift};
    s0_n    = (pend && (cnt_p == 2'd0 || FWFT == 0)) ? ram_rd_data : shift ? skid1 : skid0;
    s1_n    = (pend && cnt_p != 2'd0 && FWFT != 0) ? ram_rd_data : skid1;
    cnt_n   = (FWFT != 0) ? cnt_p + {1'b0, pend} : {1'b0, pend};
    level_n = avail_next + ((FWFT != 0) ? W1'(ram_rd_en) + W1'(cnt_n) : '0);
  end
  // Read pointer, pipeline and status registers
  always_ff @(posedge rd_clk or negedge reset)
    if (!reset) begin
      rbin         <= '0;
      rptr_gray    <= '0;
      pend         <= 1'b0;
      cnt          <= 2'd0;
      skid0        <= '0;
      skid1        <= '0;
      empty_q      <= 1'b1;
      rd_level     <= '0;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rptr_gray    <= rbin_next ^ (rbin_next >> 1);
      pend         <= ram_rd_en;
      cnt          <= cnt_n;
      skid0        <= s0_n;
      skid1        <= s1_n;
      empty_q      <= avail_next == '0;
      rd_level     <= level_n;
      almost_empty <= level_n <= AE;
      underflow    <= underflow | (pop & empty);
    end
endmodule
